// File: rtl/vend_ctrl.sv
// Vending-machine controller: collects coins, dispenses a product, pays change in 0.5-yuan coins.
// Optional collect-phase idle timeout with refund is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
    parameter int PRICE0  = 3,
    parameter int PRICE1  = 5,
    parameter int PRICE2  = 6,
    parameter int PRICE3  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       sel_vld,
    input  logic [1:0] sel,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic [1:0] disp_id,
    output logic       chg,
    output logic       coin_rej,
    output logic [4:0] credit,
    output logic       busy
);

    if (PRICE0 < 1 || PRICE0 > 15 || PRICE1 < 1 || PRICE1 > 15 ||
        PRICE2 < 1 || PRICE2 > 15 || PRICE3 < 1 || PRICE3 > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("vend_ctrl: prices must be 1..15 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t     state, state_n;
    logic [3:0] price, price_n;
    logic [1:0] prod, prod_n, disp_id_n;
    logic [4:0] credit_n, sum;
    logic       disp_req_n, chg_n, coin_rej_n, busy_n;
    logic       coin_any, coin_ok, timeout;

    function automatic logic [3:0] price_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4'(PRICE0);
            2'd1:    return 4'(PRICE1);
            2'd2:    return 4'(PRICE2);
            default: return 4'(PRICE3);
        endcase
    endfunction

    // One-hot coin bits map straight onto the coin value: d1=1, d2=2, d3=4 units.
    assign coin_any = d1 | d2 | d3;
    assign coin_ok  = ({d3, d2, d1} == 3'b001) || ({d3, d2, d1} == 3'b010) || ({d3, d2, d1} == 3'b100);
    assign sum      = credit + {2'b00, d3, d2, d1};

`ifdef VEND_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] idle_cnt;

    // Held at zero outside COLLECT, so entering COLLECT always starts a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          idle_cnt <= '0;
        else if (state != COLLECT || coin_ok) idle_cnt <= '0;
        else                               idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = (state == COLLECT) && !coin_ok && (idle_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state;
        price_n    = price;
        prod_n     = prod;
        credit_n   = credit;
        disp_req_n = disp_req;
        disp_id_n  = disp_id;
        chg_n      = 1'b0;
        coin_rej_n = coin_any && !(state == COLLECT && coin_ok);
        case (state)
            IDLE: begin
                if (sel_vld) begin
                    price_n = price_of(sel);
                    prod_n  = sel;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (coin_ok) begin
                    if (sum >= {1'b0, price}) begin
                        credit_n   = sum - {1'b0, price};
                        disp_req_n = 1'b1;
                        disp_id_n  = prod;
                        state_n    = DISPENSE;
                    end else begin
                        credit_n = sum;
                    end
                end else if (timeout) begin
                    state_n = (credit != 5'd0) ? CHANGE : IDLE;
                end
            end
            DISPENSE: begin
                if (disp_ack) begin
                    disp_req_n = 1'b0;
                    state_n    = (credit != 5'd0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                chg_n    = 1'b1;
                credit_n = credit - 5'd1;
                if (credit <= 5'd1) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            price    <= '0;
            prod     <= '0;
            credit   <= '0;
            disp_req <= 1'b0;
            disp_id  <= '0;
            chg      <= 1'b0;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            price    <= price_n;
            prod     <= prod_n;
            credit   <= credit_n;
            disp_req <= disp_req_n;
            disp_id  <= disp_id_n;
            chg      <= chg_n;
            coin_rej <= coin_rej_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus randomized purchases checked
// against a transaction-level credit model.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1, d2, d3, sel_vld, disp_ack;
    logic [1:0] sel;
    logic       disp_req, chg, coin_rej, busy;
    logic [1:0] disp_id;
    logic [4:0] credit;

    int n_checks = 0;
    int n_fail   = 0;

    vend_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .sel_vld  (sel_vld),
        .sel      (sel),
        .disp_ack (disp_ack),
        .disp_req (disp_req),
        .disp_id  (disp_id),
        .chg      (chg),
        .coin_rej (coin_rej),
        .credit   (credit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // One row: inputs for a cycle and the outputs expected right after that edge.
    typedef struct packed {
        logic [2:0]  coins;   // {d3,d2,d1}
        logic        sv;
        logic [1:0]  s;
        logic        ack;
        logic [10:0] exp;     // {busy,disp_req,disp_id,chg,coin_rej,credit}
    } row_t;

    function automatic row_t row(input logic [2:0] c, input logic sv, input logic [1:0] s, input logic a,
                                 input logic b, input logic r, input logic [1:0] id, input logic ch,
                                 input logic rj, input logic [4:0] cr);
        row_t x;
        x.coins = c; x.sv = sv; x.s = s; x.ack = a;
        x.exp   = {b, r, id, ch, rj, cr};
        return x;
    endfunction

    function automatic logic [10:0] expv(input logic b, input logic r, input logic [1:0] id,
                                         input logic ch, input logic rj, input logic [4:0] cr);
        return {b, r, id, ch, rj, cr};
    endfunction

    // disp_id only carries meaning while disp_req is high.
    function automatic logic [10:0] obs();
        return {busy, disp_req, disp_req ? disp_id : 2'b00, chg, coin_rej, credit};
    endfunction

    function automatic int price_of(input int p);
        case (p)
            0:       return 3;
            1:       return 5;
            2:       return 6;
            default: return 8;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [2:0] c, input logic sv, input logic [1:0] s, input logic a);
        {d3, d2, d1} = c; sel_vld = sv; sel = s; disp_ack = a;
        step();
        {d3, d2, d1} = 3'b000; sel_vld = 1'b0; sel = 2'd0; disp_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; {d3, d2, d1} = 3'b000; sel_vld = 1'b0; sel = 2'd0; disp_ack = 1'b0;
        #3;
        n_checks++;
        if (obs() !== 11'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", obs(), 11'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();
        n_checks++;
        if (obs() !== 11'd0) begin
            n_fail++; $display("FAIL reset_release: got %h want %h", obs(), 11'd0);
        end
    endtask

    task automatic test_basic();
        row_t q[$];
        q = {row(3'b000, 1, 0, 0,  1, 0, 0, 0, 0, 0),
             row(3'b001, 0, 0, 0,  1, 0, 0, 0, 0, 1),
             row(3'b010, 0, 0, 0,  1, 1, 0, 0, 0, 0),
             row(3'b000, 0, 0, 0,  1, 1, 0, 0, 0, 0),
             row(3'b000, 0, 0, 0,  1, 1, 0, 0, 0, 0),
             row(3'b000, 0, 0, 1,  0, 0, 0, 0, 0, 0),
             row(3'b000, 0, 0, 0,  0, 0, 0, 0, 0, 0)};
        foreach (q[i]) begin
            apply(q[i].coins, q[i].sv, q[i].s, q[i].ack);
            n_checks++;
            if (obs() !== q[i].exp) begin
                n_fail++; $display("FAIL basic[%0d]: got %h want %h", i, obs(), q[i].exp);
            end
        end
    endtask

    task automatic test_change();
        row_t q[$];
        q = {row(3'b000, 1, 1, 0,  1, 0, 0, 0, 0, 0),
             row(3'b100, 0, 0, 0,  1, 0, 0, 0, 0, 4),
             row(3'b100, 0, 0, 0,  1, 1, 1, 0, 0, 3),
             row(3'b000, 0, 0, 1,  1, 0, 0, 0, 0, 3),
             row(3'b000, 0, 0, 0,  1, 0, 0, 1, 0, 2),
             row(3'b000, 0, 0, 0,  1, 0, 0, 1, 0, 1),
             row(3'b000, 0, 0, 0,  0, 0, 0, 1, 0, 0),
             row(3'b000, 0, 0, 0,  0, 0, 0, 0, 0, 0)};
        foreach (q[i]) begin
            apply(q[i].coins, q[i].sv, q[i].s, q[i].ack);
            n_checks++;
            if (obs() !== q[i].exp) begin
                n_fail++; $display("FAIL change[%0d]: got %h want %h", i, obs(), q[i].exp);
            end
        end
    endtask

    task automatic test_reject();
        row_t q[$];
        q = {row(3'b000, 1, 0, 0,  1, 0, 0, 0, 0, 0),
             row(3'b011, 0, 0, 0,  1, 0, 0, 0, 1, 0),
             row(3'b000, 0, 0, 0,  1, 0, 0, 0, 0, 0),
             row(3'b001, 0, 0, 0,  1, 0, 0, 0, 0, 1),
             row(3'b111, 0, 0, 0,  1, 0, 0, 0, 1, 1),
             row(3'b010, 0, 0, 0,  1, 1, 0, 0, 0, 0),
             row(3'b010, 0, 0, 0,  1, 1, 0, 0, 1, 0),
             row(3'b000, 0, 0, 0,  1, 1, 0, 0, 0, 0),
             row(3'b000, 0, 0, 1,  0, 0, 0, 0, 0, 0),
             row(3'b100, 0, 0, 0,  0, 0, 0, 0, 1, 0),
             row(3'b001, 1, 0, 0,  1, 0, 0, 0, 1, 0),
             row(3'b100, 0, 0, 0,  1, 1, 0, 0, 0, 1),
             row(3'b000, 0, 0, 1,  1, 0, 0, 0, 0, 1),
             row(3'b010, 0, 0, 0,  0, 0, 0, 1, 1, 0),
             row(3'b000, 0, 0, 0,  0, 0, 0, 0, 0, 0)};
        foreach (q[i]) begin
            apply(q[i].coins, q[i].sv, q[i].s, q[i].ack);
            n_checks++;
            if (obs() !== q[i].exp) begin
                n_fail++; $display("FAIL reject[%0d]: got %h want %h", i, obs(), q[i].exp);
            end
        end
    endtask

    task automatic test_ignore();
        row_t q[$];
        q = {row(3'b000, 1, 0, 0,  1, 0, 0, 0, 0, 0),
             row(3'b000, 1, 2, 0,  1, 0, 0, 0, 0, 0),
             row(3'b000, 0, 0, 1,  1, 0, 0, 0, 0, 0),
             row(3'b010, 0, 0, 0,  1, 0, 0, 0, 0, 2),
             row(3'b001, 0, 0, 0,  1, 1, 0, 0, 0, 0),
             row(3'b000, 1, 3, 0,  1, 1, 0, 0, 0, 0),
             row(3'b000, 0, 0, 1,  0, 0, 0, 0, 0, 0),
             row(3'b000, 0, 0, 1,  0, 0, 0, 0, 0, 0)};
        foreach (q[i]) begin
            apply(q[i].coins, q[i].sv, q[i].s, q[i].ack);
            n_checks++;
            if (obs() !== q[i].exp) begin
                n_fail++; $display("FAIL ignore[%0d]: got %h want %h", i, obs(), q[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t q[$];
        q = {row(3'b000, 1, 0, 0,  1, 0, 0, 0, 0, 0),
             row(3'b001, 0, 0, 0,  1, 0, 0, 0, 0, 1),
             row(3'b100, 0, 0, 0,  1, 1, 0, 0, 0, 2),
             row(3'b000, 0, 0, 1,  1, 0, 0, 0, 0, 2)};
        foreach (q[i]) begin
            apply(q[i].coins, q[i].sv, q[i].s, q[i].ack);
            n_checks++;
            if (obs() !== q[i].exp) begin
                n_fail++; $display("FAIL rstmid_setup[%0d]: got %h want %h", i, obs(), q[i].exp);
            end
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 11'd0) begin
            n_fail++; $display("FAIL rstmid_async: got %h want %h", obs(), 11'd0);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (obs() !== 11'd0) begin
                n_fail++; $display("FAIL rstmid_hold[%0d]: got %h want %h", k, obs(), 11'd0);
            end
        end
        rst = 1'b1;
        q = {row(3'b000, 0, 0, 0,  0, 0, 0, 0, 0, 0),
             row(3'b000, 1, 2, 0,  1, 0, 0, 0, 0, 0),
             row(3'b100, 0, 0, 0,  1, 0, 0, 0, 0, 4),
             row(3'b010, 0, 0, 0,  1, 1, 2, 0, 0, 0),
             row(3'b000, 0, 0, 1,  0, 0, 0, 0, 0, 0)};
        foreach (q[i]) begin
            apply(q[i].coins, q[i].sv, q[i].s, q[i].ack);
            n_checks++;
            if (obs() !== q[i].exp) begin
                n_fail++; $display("FAIL rstmid_after[%0d]: got %h want %h", i, obs(), q[i].exp);
            end
        end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        apply(3'b000, 1, 3, 0);
        apply(3'b010, 0, 0, 0);
        n_checks++;
        if (obs() !== expv(1, 0, 0, 0, 0, 2)) begin
            n_fail++; $display("FAIL tmo_coin: got %h want %h", obs(), expv(1, 0, 0, 0, 0, 2));
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            n_checks++;
            if (obs() !== expv(1, 0, 0, 0, 0, 2)) begin
                n_fail++; $display("FAIL tmo_wait[%0d]: got %h want %h", k, obs(), expv(1, 0, 0, 0, 0, 2));
            end
        end
        step();
        n_checks++;
        if (obs() !== expv(1, 0, 0, 1, 0, 1)) begin
            n_fail++; $display("FAIL tmo_chg1: got %h want %h", obs(), expv(1, 0, 0, 1, 0, 1));
        end
        step();
        n_checks++;
        if (obs() !== expv(0, 0, 0, 1, 0, 0)) begin
            n_fail++; $display("FAIL tmo_chg2: got %h want %h", obs(), expv(0, 0, 0, 1, 0, 0));
        end
        step();
        n_checks++;
        if (obs() !== 11'd0) begin
            n_fail++; $display("FAIL tmo_idle: got %h want %h", obs(), 11'd0);
        end
    endtask
`else
    task automatic test_no_timeout();
        apply(3'b000, 1, 3, 0);
        apply(3'b010, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            step();
            n_checks++;
            if (obs() !== expv(1, 0, 0, 0, 0, 2)) begin
                n_fail++; $display("FAIL notmo_wait[%0d]: got %h want %h", k, obs(), expv(1, 0, 0, 0, 0, 2));
            end
        end
        apply(3'b100, 0, 0, 0);
        apply(3'b010, 0, 0, 0);
        n_checks++;
        if (obs() !== expv(1, 1, 3, 0, 0, 0)) begin
            n_fail++; $display("FAIL notmo_disp: got %h want %h", obs(), expv(1, 1, 3, 0, 0, 0));
        end
        apply(3'b000, 0, 0, 1);
        n_checks++;
        if (obs() !== 11'd0) begin
            n_fail++; $display("FAIL notmo_idle: got %h want %h", obs(), 11'd0);
        end
    endtask
`endif

    // Model: credit is the running coin sum; the sale fires once the sum reaches the price,
    // leaving sum-price as change paid back one unit per cycle.
    task automatic test_random();
        logic [2:0]  dbl [4] = '{3'b011, 3'b101, 3'b110, 3'b111};
        logic [2:0]  one [3] = '{3'b001, 3'b010, 3'b100};
        int          val [3] = '{1, 2, 4};
        logic [10:0] e;
        for (int t = 0; t < 30; t++) begin
            int p, price, cr, rem, budget;
            bit sold;
            p = $urandom_range(0, 3); price = price_of(p); cr = 0; rem = 0; sold = 0; budget = 0;
            apply(3'b000, 1, 2'(p), 0);
            n_checks++;
            if (obs() !== expv(1, 0, 0, 0, 0, 0)) begin
                n_fail++; $display("FAIL rnd_sel[%0d]: got %h want %h", t, obs(), expv(1, 0, 0, 0, 0, 0));
            end
            while (!sold) begin
                int r;
                r = $urandom_range(0, 9);
                budget++;
                if (budget > 100) begin
                    n_fail++; $display("FAIL rnd_budget[%0d]: got no sale want sale", t);
                    break;
                end
                if (r == 0) begin
                    apply(3'b000, 0, 0, 0);
                    e = expv(1, 0, 0, 0, 0, 5'(cr));
                end else if (r == 1) begin
                    apply(dbl[$urandom_range(0, 3)], 0, 0, 0);
                    e = expv(1, 0, 0, 0, 1, 5'(cr));
                end else if (r == 2) begin
                    apply(3'b000, 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
                    e = expv(1, 0, 0, 0, 0, 5'(cr));
                end else begin
                    int c;
                    c = $urandom_range(0, 2);
                    apply(one[c], 0, 0, 0);
                    if (cr + val[c] >= price) begin
                        rem = cr + val[c] - price; sold = 1;
                        e = expv(1, 1, 2'(p), 0, 0, 5'(rem));
                    end else begin
                        cr = cr + val[c];
                        e = expv(1, 0, 0, 0, 0, 5'(cr));
                    end
                end
                n_checks++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL rnd_collect[%0d]: got %h want %h", t, obs(), e);
                end
            end
            if (!sold) break;
            for (int w = $urandom_range(0, 3); w > 0; w--) begin
                bit coin;
                coin = ($urandom_range(0, 1) == 1);
                apply(coin ? 3'b010 : 3'b000, 1, 2'($urandom_range(0, 3)), 0);
                e = expv(1, 1, 2'(p), 0, coin, 5'(rem));
                n_checks++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL rnd_hold[%0d]: got %h want %h", t, obs(), e);
                end
            end
            apply(3'b000, 0, 0, 1);
            e = expv(rem > 0, 0, 0, 0, 0, 5'(rem));
            n_checks++;
            if (obs() !== e) begin
                n_fail++; $display("FAIL rnd_ack[%0d]: got %h want %h", t, obs(), e);
            end
            for (int k = rem; k > 0; k--) begin
                step();
                e = expv(k > 1, 0, 0, 1, 0, 5'(k - 1));
                n_checks++;
                if (obs() !== e) begin
                    n_fail++; $display("FAIL rnd_refund[%0d]: got %h want %h", t, obs(), e);
                end
            end
            step();
            n_checks++;
            if (obs() !== 11'd0) begin
                n_fail++; $display("FAIL rnd_idle[%0d]: got %h want %h", t, obs(), 11'd0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_change();
        test_reject();
        test_ignore();
        test_reset_mid();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached want test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameters SHALL be: PRICE0 default 3, price of product 0 in half-yuan units; PRICE1 default 5; PRICE2 default 6; PRICE3 default 8; TIMEOUT default 16, idle cycles before refund; all prices SHALL be 1..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 d1  input  1  one-cycle pulse, 0.5-yuan coin (1 unit).
REQ-005 d2  input  1  one-cycle pulse, 1-yuan coin (2 units).
REQ-006 d3  input  1  one-cycle pulse, 2-yuan coin (4 units).
REQ-007 sel_vld  input  1  one-cycle product-select strobe.
REQ-008 sel  input  2  product index, sampled with sel_vld.
REQ-009 disp_ack  input  1  dispenser accepted the request.
REQ-010 disp_req  output  1  dispense request, level, held until acknowledged.
REQ-011 disp_id  output  2  product being dispensed, valid while disp_req is high.
REQ-012 chg  output  1  one-cycle pulse per 0.5-yuan change coin.
REQ-013 coin_rej  output  1  one-cycle pulse, coin returned.
REQ-014 credit  output  5  current credit in units.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, COLLECT, DISPENSE and CHANGE; all outputs SHALL be registered.
REQ-017 In IDLE, sel_vld at edge N SHALL latch the price and id of sel and enter COLLECT at edge N; credit SHALL remain 0.
REQ-018 sel_vld outside IDLE SHALL be ignored, and disp_ack outside DISPENSE SHALL be ignored.
REQ-019 In COLLECT, a valid coin (exactly one of d1/d2/d3 high) SHALL add 1/2/4 units to credit at the same edge.
REQ-020 If credit plus coin is at least the price, the same edge SHALL set credit to credit+coin-price, raise disp_req with disp_id, and enter DISPENSE.
REQ-021 Two or more coin bits high in one cycle, or any coin outside COLLECT, SHALL leave credit unchanged and pulse coin_rej on the next cycle.
REQ-022 In DISPENSE, disp_req SHALL stay high until disp_ack is sampled high; at that edge disp_req SHALL drop and the FSM SHALL enter CHANGE if credit>0, else IDLE.
REQ-023 In CHANGE, each cycle SHALL pulse chg and decrement credit by 1; when credit reaches 0 the FSM SHALL enter IDLE on that same edge.
REQ-024 Credit SHALL never exceed 18 units (price-1+4), and a 5-bit width SHALL therefore never wrap.

Reset
REQ-025 On rst low, the FSM SHALL enter IDLE immediately, and credit, disp_req, disp_id, chg, coin_rej, busy and the timeout counter SHALL all clear to 0.
REQ-026 A reset mid-transaction SHALL discard credit with no refund pulses.

Configuration
REQ-027 With VEND_TIMEOUT_EN defined, a counter SHALL clear on entry to COLLECT and on each accepted coin; after TIMEOUT consecutive COLLECT cycles without a coin, the FSM SHALL enter CHANGE (refunding all credit) if credit>0, else IDLE.
REQ-028 Without VEND_TIMEOUT_EN, the counter logic SHALL be absent and COLLECT SHALL wait indefinitely.

Verification
REQ-029 sel=0, d1,d2 pulses -> credit 1,3→0 at the d2 edge; disp_req=1, disp_id=0; ack after 2 cycles -> IDLE; no chg pulses.
REQ-030 sel=1 (5), d3,d3 -> credit 4, then remainder 3; after ack, 3 chg pulses with credit 3,2,1→0, then busy=0.
REQ-031 A d1+d2 simultaneous pulse in COLLECT -> credit unchanged, coin_rej pulse next cycle; a d2 during DISPENSE -> coin_rej, credit unchanged.
REQ-032 With VEND_TIMEOUT_EN, sel=3, d2, then 16 idle cycles -> CHANGE with 2 chg pulses, then IDLE, disp_req never asserted.
REQ-033 Reset asserted in CHANGE with credit 2 -> all outputs 0 immediately, no further chg; a later sel_vld is accepted normally.
REQ-034 sel_vld with sel=2 while in COLLECT for product 0 -> ignored; the price stays 3.
